// File: rtl/regfile_pkg.sv
// Shared defaults, register-index type and population-count helper for the
// multi-port register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

   // Widest register file the popcount helper supports; callers narrow the result.
   localparam int unsigned NREGS_MAX = 1024;
   localparam int unsigned AW_MAX    = $clog2(NREGS_MAX);

   typedef logic [AW_DEF-1:0] reg_idx_t;

   function automatic logic [AW_MAX:0] popcount(input logic [NREGS_MAX-1:0] vec);
      logic [AW_MAX:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(NREGS_MAX); i++) begin
         cnt = cnt + {{AW_MAX{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write ports,
// reserve/flush controls and the busy counter.
interface regfile_mp_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NR    = 2,
   parameter int unsigned NW    = 1,
   parameter int unsigned AW    = $clog2(NREGS)
);

   logic [NR-1:0][AW-1:0]   rs_addr_i;
   logic [NR-1:0][XLEN-1:0] rs_data_o;
   logic [NR-1:0]           rs_busy_o;
   logic [NW-1:0]           wr_en_i;
   logic [NW-1:0][AW-1:0]   wr_addr_i;
   logic [NW-1:0][XLEN-1:0] wr_data_i;
   logic                    rsv_en_i;
   logic [AW-1:0]           rsv_addr_i;
   logic                    flush_i;
   logic [AW:0]             busy_cnt_o;

   modport slave (
      input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
      output rs_data_o, rs_busy_o, busy_cnt_o
   );

   modport master (
      output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i, flush_i,
      input  rs_data_o, rs_busy_o, busy_cnt_o
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for RAW stalls: flush > reserve > write-clear,
// registered busy count, and bypass-aware busy flags on each read port.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NR    = 2,
   parameter int unsigned NW    = 1,
   localparam int unsigned AW   = $clog2(NREGS),
   localparam int unsigned CW   = AW + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NR-1:0][AW-1:0] rs_addr_i,
   output logic [NR-1:0]         rs_busy_o,
   input  logic [NW-1:0]         wr_en_i,
   input  logic [NW-1:0][AW-1:0] wr_addr_i,
   input  logic                  rsv_en_i,
   input  logic [AW-1:0]         rsv_addr_i,
   input  logic                  flush_i,
   output logic [CW-1:0]         busy_cnt_o
);

   logic [NREGS-1:1]     busy_q;
   logic [NREGS-1:1]     busy_d;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_d;
   logic [NREGS_MAX-1:0] busy_pad;

   // Reserve is applied after write-clears so it names the newest producer.
   always_comb begin
      busy_d   = busy_q;
      busy_pad = '0;
      for (int p = 0; p < int'(NW); p++) begin
         if (wr_en_i[p] && (wr_addr_i[p] != '0)) begin
            busy_d[wr_addr_i[p]] = 1'b0;
         end
      end
      if (rsv_en_i && (rsv_addr_i != '0)) begin
         busy_d[rsv_addr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      busy_pad[NREGS-1:1] = busy_d;
      cnt_d = CW'(popcount(busy_pad));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_cnt_o = cnt_q;

   // A same-cycle write bypasses its data, so the reader need not stall.
   always_comb begin
      logic [AW-1:0] a;
      rs_busy_o = '0;
      for (int r = 0; r < int'(NR); r++) begin
         a = rs_addr_i[r];
         if (a != '0) begin
            rs_busy_o[r] = busy_q[a];
            for (int p = 0; p < int'(NW); p++) begin
               if (wr_en_i[p] && (wr_addr_i[p] == a)) begin
                  rs_busy_o[r] = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: x0 hardwired to zero, highest write port
// wins, same-cycle write-to-read bypass, busy scoreboard for decode stalls.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned NR    = 2,
   parameter int unsigned NW    = 1,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   regfile_mp_if.slave   bus
);

   logic [NREGS-1:1][XLEN-1:0] regs_q;
   logic [NREGS-1:1][XLEN-1:0] regs_d;
   logic [NR-1:0][XLEN-1:0]    rd_data;

   // Ascending port order lets the highest-indexed writer win.
   always_comb begin
      regs_d = regs_q;
      for (int p = 0; p < int'(NW); p++) begin
         if (bus.wr_en_i[p] && (bus.wr_addr_i[p] != '0)) begin
            regs_d[bus.wr_addr_i[p]] = bus.wr_data_i[p];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read mux with bypass from the highest matching write port.
   always_comb begin
      logic [AW-1:0] a;
      rd_data = '0;
      for (int r = 0; r < int'(NR); r++) begin
         a = bus.rs_addr_i[r];
         if (a != '0) begin
            rd_data[r] = regs_q[a];
            for (int p = 0; p < int'(NW); p++) begin
               if (bus.wr_en_i[p] && (bus.wr_addr_i[p] == a)) begin
                  rd_data[r] = bus.wr_data_i[p];
               end
            end
         end
      end
   end

   assign bus.rs_data_o = rd_data;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NR    (NR),
      .NW    (NW)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rs_addr_i  (bus.rs_addr_i),
      .rs_busy_o  (bus.rs_busy_o),
      .wr_en_i    (bus.wr_en_i),
      .wr_addr_i  (bus.wr_addr_i),
      .rsv_en_i   (bus.rsv_en_i),
      .rsv_addr_i (bus.rsv_addr_i),
      .flush_i    (bus.flush_i),
      .busy_cnt_o (bus.busy_cnt_o)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NW=2): directed bypass/scoreboard/reset
// cases followed by a randomized data run against a reference array.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NR    = 2;
   localparam int unsigned NW    = 2;
   localparam int unsigned AW    = $clog2(NREGS);

   localparam int SEL_D0 = 0;
   localparam int SEL_D1 = 1;
   localparam int SEL_B0 = 2;
   localparam int SEL_B1 = 3;
   localparam int SEL_CNT = 4;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic [31:0] model [NREGS];

   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW), .AW(AW)) bus ();

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      sb.push_back(x);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_D0:  return bus.rs_data_o[0];
         SEL_D1:  return bus.rs_data_o[1];
         SEL_B0:  return {31'd0, bus.rs_busy_o[0]};
         SEL_B1:  return {31'd0, bus.rs_busy_o[1]};
         default: return 32'(bus.busy_cnt_o);
      endcase
   endfunction

   task automatic drain();
      exp_t x;
      while (sb.size() > 0) begin
         x = sb.pop_front();
         check(x.tag, observe(x.sel), x.exp);
      end
   endtask

   task automatic cyc_begin();
      @(negedge clk);
      bus.wr_en_i    = '0;
      bus.wr_addr_i  = '0;
      bus.wr_data_i  = '0;
      bus.rsv_en_i   = 1'b0;
      bus.rsv_addr_i = '0;
      bus.flush_i    = 1'b0;
   endtask

   task automatic settle();
      #2;
      drain();
   endtask

   task automatic rd(input int a0, input int a1);
      bus.rs_addr_i[0] = AW'(a0);
      bus.rs_addr_i[1] = AW'(a1);
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d);
      bus.wr_en_i[p]   = 1'b1;
      bus.wr_addr_i[p] = AW'(a);
      bus.wr_data_i[p] = d;
   endtask

   task automatic rsv(input int a);
      bus.rsv_en_i   = 1'b1;
      bus.rsv_addr_i = AW'(a);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.rs_addr_i  = '0;
      bus.wr_en_i    = '0;
      bus.wr_addr_i  = '0;
      bus.wr_data_i  = '0;
      bus.rsv_en_i   = 1'b0;
      bus.rsv_addr_i = '0;
      bus.flush_i    = 1'b0;

      // In reset: writes ignored, bypass still visible, counters zero.
      rd(5, 8);
      wr(0, 8, 32'h0000_0BAD);
      rsv(8);
      #12;
      push("rst_d1", SEL_D1, 32'h0000_0BAD);
      push("rst_b1", SEL_B1, 0);
      push("rst_cnt", SEL_CNT, 0);
      push("rst_d0", SEL_D0, 0);
      settle();
      @(negedge clk);
      bus.wr_en_i = '0;
      bus.rsv_en_i = 1'b0;
      rst_n = 1'b1;

      cyc_begin(); rd(5, 8); wr(0, 5, 32'hDEAD_BEEF);
      push("wr_bypass", SEL_D0, 32'hDEAD_BEEF);
      push("rst_wr_dropped", SEL_D1, 0);
      settle();
      cyc_begin(); rd(5, 0);
      push("wr_held1", SEL_D0, 32'hDEAD_BEEF); settle();
      cyc_begin(); rd(5, 5);
      push("wr_held2_p0", SEL_D0, 32'hDEAD_BEEF);
      push("wr_held2_p1", SEL_D1, 32'hDEAD_BEEF); settle();

      cyc_begin(); rd(0, 0); wr(0, 0, 32'h1234);
      push("x0_byp_p0", SEL_D0, 0); push("x0_byp_p1", SEL_D1, 0); settle();
      cyc_begin(); rd(0, 0); rsv(0);
      push("x0_rd_p0", SEL_D0, 0); push("x0_rd_p1", SEL_D1, 0); settle();
      cyc_begin(); rd(0, 0);
      push("x0_busy", SEL_B0, 0); push("x0_cnt", SEL_CNT, 0); settle();

      cyc_begin(); rd(7, 0); wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555);
      push("wprio_byp", SEL_D0, 32'h5555); settle();
      cyc_begin(); rd(7, 7);
      push("wprio_p0", SEL_D0, 32'h5555); push("wprio_p1", SEL_D1, 32'h5555); settle();

      cyc_begin(); rd(3, 0); rsv(3);
      push("rsv_not_yet", SEL_B0, 0); settle();
      cyc_begin(); rd(3, 0);
      push("rsv_busy", SEL_B0, 1); push("rsv_cnt", SEL_CNT, 1); settle();
      cyc_begin(); rd(3, 0); wr(0, 3, 32'h42);
      push("clr_mask", SEL_B0, 0); push("clr_data", SEL_D0, 32'h42);
      push("clr_cnt_lag", SEL_CNT, 1); settle();
      cyc_begin(); rd(3, 0);
      push("clr_cnt", SEL_CNT, 0); push("clr_busy", SEL_B0, 0);
      push("clr_held", SEL_D0, 32'h42); settle();

      cyc_begin(); rd(3, 0); rsv(3); wr(0, 3, 32'h77);
      push("rsvwr_byp", SEL_D0, 32'h77); push("rsvwr_mask", SEL_B0, 0); settle();
      cyc_begin(); rd(3, 4); rsv(4); bus.flush_i = 1'b1;
      push("rsvwr_data", SEL_D0, 32'h77); push("rsvwr_busy", SEL_B0, 1);
      push("rsvwr_cnt", SEL_CNT, 1); settle();
      cyc_begin(); rd(3, 4);
      push("flush_b0", SEL_B0, 0); push("flush_b1", SEL_B1, 0);
      push("flush_cnt", SEL_CNT, 0); settle();

      cyc_begin(); rd(6, 0); rsv(6); settle();
      cyc_begin(); rd(6, 0); rsv(6);
      push("dbl_busy", SEL_B0, 1); push("dbl_cnt1", SEL_CNT, 1); settle();
      cyc_begin(); rd(6, 0); bus.flush_i = 1'b1;
      push("dbl_cnt2", SEL_CNT, 1); settle();
      cyc_begin(); rd(6, 0);
      push("dbl_flush", SEL_CNT, 0); settle();

      cyc_begin(); rsv(1); settle();
      cyc_begin(); rsv(2); settle();
      cyc_begin(); rsv(9); settle();
      cyc_begin(); rd(9, 1);
      push("pre_b0", SEL_B0, 1); push("pre_b1", SEL_B1, 1);
      push("pre_cnt", SEL_CNT, 3); settle();
      rst_n = 1'b0;
      #1;
      push("arst_b0", SEL_B0, 0); push("arst_b1", SEL_B1, 0);
      push("arst_cnt", SEL_CNT, 0); drain();
      rd(5, 7);
      #1;
      push("arst_d0", SEL_D0, 0); push("arst_d1", SEL_D1, 0); drain();
      cyc_begin(); rst_n = 1'b1; rd(2, 3);
      push("post_b0", SEL_B0, 0); push("post_cnt", SEL_CNT, 0);
      push("post_d1", SEL_D1, 0); settle();

      // Randomized writes/reads with bypass against a reference array.
      for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
      for (int c = 0; c < 60; c++) begin
         int a [NR];
         int wa [NW];
         logic [31:0] wd [NW];
         logic [NW-1:0] we;
         logic [31:0] e;
         cyc_begin();
         for (int p = 0; p < int'(NW); p++) begin
            we[p] = 1'($urandom_range(0, 1));
            wa[p] = int'($urandom_range(0, 7));
            wd[p] = $urandom;
            if (we[p]) wr(p, wa[p], wd[p]);
         end
         for (int r = 0; r < int'(NR); r++) begin
            a[r] = ($urandom_range(0, 2) == 0) ? wa[r] : int'($urandom_range(0, 7));
            e = (a[r] == 0) ? 32'd0 : model[a[r]];
            for (int p = 0; p < int'(NW); p++) begin
               if (we[p] && wa[p] == a[r] && a[r] != 0) e = wd[p];
            end
            push((r == 0) ? "rnd_d0" : "rnd_d1", (r == 0) ? SEL_D0 : SEL_D1, e);
         end
         rd(a[0], a[1]);
         settle();
         for (int p = 0; p < int'(NW); p++) begin
            if (we[p] && wa[p] != 0) model[wa[p]] = wd[p];
         end
      end

      cyc_begin();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
